// File: rtl/banked_data_mem.sv
// banked_data_mem: NBANKS-way interleaved 16-bit word memory with two read ports
// (fetch = port 0, ld = port 1) and one write port (st).
// Banks are selected by the low word-address bits. Read data returns two cycles
// after acceptance. Bank conflicts are resolved with priority write > port 1 > port 0.

// One single-ported bank: one read or one write per cycle, registered read data.
module banked_data_mem_bank #(
  parameter int DEPTH = 2048,
  parameter int RW    = 11
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [RW-1:0] row,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);
  logic [15:0] mem [DEPTH];
  logic [15:0] rdata_q, rdata_d;

  // Read data is only updated by an actual read, so it holds between accesses.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem[row];
  end

  // Storage. It has no reset: contents must survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (en && we) mem[row] <= wdata;
  end

  // Registered bank output. This is the first of the two read-latency stages.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

module banked_data_mem #(
  parameter int NBANKS     = 16,
  parameter int BANK_DEPTH = 2048,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd0_req,
  input  logic [15:0]      rd0_addr,
  output logic             rd0_ready,
  output logic             rd0_rvalid,
  output logic [15:0]      rd0_data,
  input  logic             rd1_req,
  input  logic [15:0]      rd1_addr,
  output logic             rd1_ready,
  output logic             rd1_rvalid,
  output logic [15:0]      rd1_data,
  input  logic             wr_en,
  input  logic [15:0]      wr_addr,
  input  logic [15:0]      wr_data,
  output logic             wr_ready,
  output logic [CNT_W-1:0] conflict_cnt
);
  localparam int BW = $clog2(NBANKS);
  localparam int RW = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;

  // The bank index is the low word-address bits.
  function automatic logic [BW-1:0] bank_of(input logic [15:0] a);
    return a[BW:1];
  endfunction

  // The row is the word address above the bank bits. Taking it modulo BANK_DEPTH
  // makes out-of-range words alias modulo total capacity.
  function automatic logic [RW-1:0] row_of(input logic [15:0] a);
    return RW'((a[15:1] >> BW) % 15'(BANK_DEPTH));
  endfunction

  logic [BW-1:0] b0, b1, bw;
  logic [RW-1:0] r0, r1, rw;
  logic          wr_go, rd0_acc, rd1_acc;

  logic [NBANKS-1:0]         bank_en, bank_we;
  logic [NBANKS-1:0][RW-1:0] bank_row;
  logic [NBANKS-1:0][15:0]   bank_rdata;

  logic [2:1]       rd0_vld_pipe_q, rd0_vld_pipe_d, rd1_vld_pipe_q, rd1_vld_pipe_d;
  logic [BW-1:0]    rd0_bank_q, rd0_bank_d, rd1_bank_q, rd1_bank_d;
  logic [15:0]      rd0_data_q, rd0_data_d, rd1_data_q, rd1_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             conflict;

  // Byte-lane bit 0 of each address is not used.
  logic unused_lsb;
  assign unused_lsb = ^{rd0_addr[0], rd1_addr[0], wr_addr[0]};

  // Arbitration. The write always wins. Port 1 loses only to the write.
  // Port 0 also loses to port 1 on the same bank with a different row.
  // Same bank and same row is a shared read.
  always_comb begin
    b0 = bank_of(rd0_addr);
    b1 = bank_of(rd1_addr);
    bw = bank_of(wr_addr);
    r0 = row_of(rd0_addr);
    r1 = row_of(rd1_addr);
    rw = row_of(wr_addr);
    wr_go   = wr_en && !rst;
    rd1_acc = rd1_req && !rst && !(wr_en && (bw == b1));
    rd0_acc = rd0_req && !rst && !(wr_en && (bw == b0))
              && !(rd1_acc && (b1 == b0) && (r1 != r0));
    rd0_ready = !rst && (!rd0_req || rd0_acc);
    rd1_ready = !rst && (!rd1_req || rd1_acc);
    conflict  = (rd0_req && !rd0_ready) || (rd1_req && !rd1_ready);
  end

  assign wr_ready = 1'b1;

  for (genvar g = 0; g < NBANKS; g++) begin : g_bank
    logic hit_w, hit1, hit0;
    assign hit_w = wr_go   && (bw == BW'(g));
    assign hit1  = rd1_acc && (b1 == BW'(g));
    assign hit0  = rd0_acc && (b0 == BW'(g));
    assign bank_en[g]  = hit_w || hit1 || hit0;
    assign bank_we[g]  = hit_w;
    // Port 0 uses its own row only when port 1 is not reading this bank.
    // A shared read has equal rows, so port 1's row serves both.
    assign bank_row[g] = hit_w ? rw : (hit1 ? r1 : r0);

    banked_data_mem_bank #(.DEPTH(BANK_DEPTH), .RW(RW)) u_bank (
      .clk   (clk),
      .en    (bank_en[g]),
      .we    (bank_we[g]),
      .row   (bank_row[g]),
      .wdata (wr_data),
      .rdata (bank_rdata[g])
    );
  end

  // Read return pipeline: acceptance -> bank read (t+1) -> output register (t+2).
  // Each port keeps the bank index of its accepted read, to select the returning data.
  always_comb begin
    rd0_vld_pipe_d = {rd0_vld_pipe_q[1], rd0_acc};
    rd1_vld_pipe_d = {rd1_vld_pipe_q[1], rd1_acc};
    rd0_bank_d     = rd0_acc ? b0 : rd0_bank_q;
    rd1_bank_d     = rd1_acc ? b1 : rd1_bank_q;
    rd0_data_d     = rd0_vld_pipe_q[1] ? bank_rdata[rd0_bank_q] : rd0_data_q;
    rd1_data_d     = rd1_vld_pipe_q[1] ? bank_rdata[rd1_bank_q] : rd1_data_q;
    cnt_d          = cnt_q;
    if (conflict && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // Pipeline and counter state. Reset drops in-flight reads and clears outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd0_vld_pipe_q <= '0;
      rd1_vld_pipe_q <= '0;
      rd0_data_q     <= '0;
      rd1_data_q     <= '0;
      cnt_q          <= '0;
    end else begin
      rd0_vld_pipe_q <= rd0_vld_pipe_d;
      rd1_vld_pipe_q <= rd1_vld_pipe_d;
      rd0_data_q     <= rd0_data_d;
      rd1_data_q     <= rd1_data_d;
      cnt_q          <= cnt_d;
    end
    rd0_bank_q <= rd0_bank_d;
    rd1_bank_q <= rd1_bank_d;
  end

  assign rd0_rvalid   = rd0_vld_pipe_q[2];
  assign rd1_rvalid   = rd1_vld_pipe_q[2];
  assign rd0_data     = rd0_data_q;
  assign rd1_data     = rd1_data_q;
  assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_banked_data_mem.sv
// Testbench for banked_data_mem: directed scenarios, then random traffic, all
// checked against a word-array model of the memory and a due-cycle queue per read port.
module tb_banked_data_mem;
  localparam int NBANKS = 16, BANK_DEPTH = 2048, CNT_W = 4;
  localparam int CAP = NBANKS * BANK_DEPTH;

  logic clk = 0, rst;
  logic rd0_req, rd1_req, wr_en;
  logic [15:0] rd0_addr, rd1_addr, wr_addr, wr_data;
  logic rd0_ready, rd1_ready, rd0_rvalid, rd1_rvalid, wr_ready;
  logic [15:0] rd0_data, rd1_data;
  logic [CNT_W-1:0] conflict_cnt;

  banked_data_mem #(.NBANKS(NBANKS), .BANK_DEPTH(BANK_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_ready(rd0_ready),
    .rd0_rvalid(rd0_rvalid), .rd0_data(rd0_data),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_ready(rd1_ready),
    .rd1_rvalid(rd1_rvalid), .rd1_data(rd1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [15:0] data; } exp_t;
  exp_t q0[$], q1[$];
  logic [15:0] mem [CAP];
  int cyc = 0, mcnt = 0, nvec = 0, nerr = 0;

  function automatic int wd(input logic [15:0] a); return int'(a >> 1) % CAP; endfunction
  function automatic int bk(input logic [15:0] a); return wd(a) % NBANKS; endfunction
  function automatic int rw(input logic [15:0] a); return wd(a) / NBANKS; endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic [15:0] ad0, input logic r1,
                       input logic [15:0] ad1, input logic we, input logic [15:0] wa,
                       input logic [15:0] wdat);
    rd0_req = r0; rd0_addr = ad0; rd1_req = r1; rd1_addr = ad1;
    wr_en = we; wr_addr = wa; wr_data = wdat;
  endtask

  task automatic idle(); drive(0, 0, 0, 0, 0, 0, 0); endtask

  // One cycle: check all outputs mid-cycle against the model, advance the model, clock.
  task automatic step();
    logic a0, a1, e0, e1, wconf0, wconf1;
    exp_t e;
    @(negedge clk);
    wconf1 = wr_en && bk(wr_addr) == bk(rd1_addr);
    wconf0 = wr_en && bk(wr_addr) == bk(rd0_addr);
    a1 = rd1_req && !rst && !wconf1;
    a0 = rd0_req && !rst && !wconf0 &&
         !(a1 && bk(rd1_addr) == bk(rd0_addr) && rw(rd1_addr) != rw(rd0_addr));
    e1 = !rst && (!rd1_req || a1);
    e0 = !rst && (!rd0_req || a0);
    chk("rd0_ready", rd0_ready, e0);
    chk("rd1_ready", rd1_ready, e1);
    chk("wr_ready", wr_ready, 1);
    if (q0.size() > 0 && q0[0].due == cyc) begin
      e = q0.pop_front();
      chk("rd0_rvalid", rd0_rvalid, 1);
      chk("rd0_data", rd0_data, e.data);
    end else chk("rd0_rvalid", rd0_rvalid, 0);
    if (q1.size() > 0 && q1[0].due == cyc) begin
      e = q1.pop_front();
      chk("rd1_rvalid", rd1_rvalid, 1);
      chk("rd1_data", rd1_data, e.data);
    end else chk("rd1_rvalid", rd1_rvalid, 0);
    chk("conflict_cnt", conflict_cnt, mcnt);
    if (rst) begin
      q0.delete(); q1.delete(); mcnt = 0;
    end else begin
      if (a0) q0.push_back('{cyc + 2, mem[wd(rd0_addr)]});
      if (a1) q1.push_back('{cyc + 2, mem[wd(rd1_addr)]});
      if (((rd0_req && !e0) || (rd1_req && !e1)) && mcnt < (1 << CNT_W) - 1) mcnt++;
      if (wr_en) mem[wd(wr_addr)] = wr_data;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    drive(0, 0, 0, 0, 1, a, d); step();
  endtask

  task automatic idles(input int n);
    idle(); for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1; idle();
    @(posedge clk); #1;
    // Reset state: ready low under reset even with requests pending.
    drive(1, 16'h0000, 1, 16'h0002, 0, 0, 0);
    step();
    chk("rst_rd0_data", rd0_data, 0);
    chk("rst_rd1_data", rd1_data, 0);
    rst = 0;
    idles(1);

    // A write is followed by a read of the same word one cycle later.
    wr(16'h0004, 16'h1234);
    drive(0, 0, 1, 16'h0004, 0, 0, 0); step();
    idles(3);

    // Port 0 loses to port 1 on the same bank with a different row, then retries.
    wr(16'h0000, 16'hAAAA);
    wr(16'h0020, 16'hBBBB);
    drive(1, 16'h0000, 1, 16'h0020, 0, 0, 0); step();
    chk("conflict_one", conflict_cnt, 1);
    drive(1, 16'h0000, 0, 0, 0, 0, 0); step();
    idles(3);

    // Shared read of one word.
    wr(16'h0006, 16'h6666);
    drive(1, 16'h0006, 1, 16'h0006, 0, 0, 0); step();
    idles(3);

    // A write blocks port 1 on the same bank. The retry returns the untouched word.
    wr(16'h0028, 16'h2828);
    drive(0, 0, 1, 16'h0028, 1, 16'h0008, 16'h0808); step();
    drive(0, 0, 1, 16'h0028, 0, 0, 0); step();
    drive(0, 0, 1, 16'h0008, 0, 0, 0); step();
    idles(3);

    // Back-to-back reads on four banks.
    drive(1, 16'h0000, 0, 0, 0, 0, 0); step();
    drive(1, 16'h0002, 0, 0, 0, 0, 0); step();
    drive(1, 16'h0004, 0, 0, 0, 0, 0); step();
    drive(1, 16'h0006, 0, 0, 0, 0, 0); step();
    idles(3);

    // Reset kills an in-flight read and ignores a concurrent write.
    wr(16'h000A, 16'h5555);
    drive(0, 0, 1, 16'h0004, 0, 0, 0); step();
    rst = 1; drive(1, 16'h0002, 1, 16'h0004, 1, 16'h000A, 16'hDEAD); step();
    rst = 0; idles(1);
    chk("post_rst_rd0_data", rd0_data, 0);
    chk("post_rst_rd1_data", rd1_data, 0);
    drive(1, 16'h000A, 1, 16'h0004, 0, 0, 0); step();
    idles(3);

    // The conflict counter saturates.
    for (int i = 0; i < 20; i++) begin
      drive(1, 16'h0000, 1, 16'h0020, 0, 0, 0); step();
    end
    idles(1);
    chk("cnt_saturated", conflict_cnt, (1 << CNT_W) - 1);

    // Random traffic over a 64-word pool spanning every bank and four rows.
    for (int i = 0; i < 64; i++) wr(16'(2 * i), 16'($urandom));
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive(1'($urandom), 16'(2 * $urandom_range(0, 63)),
            1'($urandom), 16'(2 * $urandom_range(0, 63)),
            $urandom_range(0, 2) == 0, 16'(2 * $urandom_range(0, 63)), 16'($urandom));
      step();
    end
    rst = 0;
    idles(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
